mem_req_ctrl: RTL and testbench

- Request controller directly upstream of the test RAM. Accepts one load/store at a time from the CPU memory stage over a valid/ready handshake and range-checks it against the RAM window.
- Drives the RAM's cs/we/addr/data_in/write_width. Captures the RAM's one-cycle registered read data and returns a sign/zero-extended 64-bit result over a valid/ready response channel.

---
 rtl/mem_req_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_req_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Load/store request controller in front of the test RAM: range-checks one
// request at a time, drives the RAM for one cycle and returns an extended result.
module mem_req_ctrl #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [1:0]  ram_width,
  input  logic [63:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  // The RAM always touches word off[63:3]+1, so the last 8 bytes are unusable.
  localparam logic [63:0] LIMIT = 64'(MEM_BYTES) - 64'd8;

  state_t      state;
  logic [1:0]  lat_width;
  logic        lat_signed;

  logic        accept;
  logic [63:0] off;
  logic [63:0] size;
  logic [63:0] end_off;
  logic        carry;
  logic        in_range;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    size = 64'd8;
    case (req_width)
      2'd0:    size = 64'd8;
      2'd1:    size = 64'd4;
      2'd2:    size = 64'd2;
      default: size = 64'd1;
    endcase
  end

  assign off              = req_addr - BASE_ADDR;
  assign {carry, end_off} = {1'b0, off} + {1'b0, size};
  assign in_range         = (req_addr >= BASE_ADDR) && !carry && (end_off <= LIMIT);

  assign ram_cs    = accept && in_range;
  assign ram_we    = ram_cs && req_we;
  assign ram_addr  = off;
  assign ram_wdata = req_wdata;
  assign ram_width = req_width;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] w,
                                         input logic s);
    case (w)
      2'd0:    return d;
      2'd1:    return {{32{s & d[31]}}, d[31:0]};
      2'd2:    return {{48{s & d[15]}}, d[15:0]};
      default: return {{56{s & d[7]}}, d[7:0]};
    endcase
  endfunction

  // NOTE: all state updates use <= so every register samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register here is plain flops (no memory array), so all are reset.
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      lat_width  <= 2'd0;
      lat_signed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_range && !req_we) begin
              lat_width  <= req_width;
              lat_signed <= req_signed;
              state      <= RD_WAIT;
            end else begin
              resp_valid <= 1'b1;
              resp_rdata <= 64'd0;
              resp_err   <= !in_range;
              state      <= RESP;
            end
          end
        end
        RD_WAIT: begin
          resp_valid <= 1'b1;
          resp_rdata <= extend(ram_rdata, lat_width, lat_signed);
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: byte-array RAM model plus a byte-level shadow memory
// that predicts every response from the addressing and extension rules.
module tb_mem_req_ctrl;

  localparam logic [63:0] BASE = 64'h1000;
  localparam int          MEMB = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        ram_cs, ram_we;
  logic [63:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  ram_width;

  int compared   = 0;
  int mismatched = 0;
  int cs_pulses  = 0;

  logic [7:0] ram_arr [MEMB];
  logic [7:0] shadow  [MEMB];

  mem_req_ctrl #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_width(req_width), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_width(ram_width), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered 8-byte read at ram_addr, little-endian write of width bytes.
  always @(posedge clk) begin : ram_model
    logic [63:0] rd;
    int          a;
    if (ram_cs) begin
      cs_pulses <= cs_pulses + 1;
      a = int'(ram_addr % 64'(MEMB));
      for (int i = 0; i < 8; i++) rd[8*i +: 8] = ram_arr[(a + i) % MEMB];
      ram_rdata <= rd;
      if (ram_we)
        for (int i = 0; i < (8 >> ram_width); i++)
          ram_arr[(a + i) % MEMB] <= ram_wdata[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: error if below the window or if the access would reach the last 8 bytes.
  task automatic model(input logic we, input logic [63:0] addr, input logic [1:0] w,
                       input logic sgn, input logic [63:0] wd,
                       output logic err, output logic [63:0] rdata, output int lat);
    int          sz;
    int          nbits;
    logic [63:0] mask;
    sz    = 8 >> w;
    nbits = 8 * sz;
    err   = (addr < BASE) || ((addr - BASE) > 64'(MEMB - 8 - sz));
    rdata = 64'd0;
    lat   = 1;
    if (!err && we) begin
      for (int i = 0; i < sz; i++) shadow[int'(addr - BASE) + i] = wd[8*i +: 8];
    end else if (!err) begin
      lat = 2;
      for (int i = 0; i < sz; i++) rdata[8*i +: 8] = shadow[int'(addr - BASE) + i];
      mask = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
      if (sgn && rdata[nbits-1]) rdata = rdata | ~mask;
    end
  endtask

  task automatic do_req(input logic we, input logic [63:0] addr, input logic [1:0] w,
                        input logic sgn, input logic [63:0] wd, input int hold,
                        input bit keep_valid, output logic [63:0] got);
    logic        exp_err;
    logic [63:0] exp_data;
    int          exp_lat, lat, n, cs0;
    model(we, addr, w, sgn, wd, exp_err, exp_data, exp_lat);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", req_ready, 1);
    cs0        = cs_pulses;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_width  = w;
    req_signed = sgn;
    req_wdata  = wd;
    #1;
    check("ram_cs_on_accept", ram_cs, !exp_err);
    check("ram_we_on_accept", ram_we, !exp_err && we);
    @(negedge clk);
    lat = 1;
    if (!keep_valid) req_valid = 1'b0;
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_rdata", resp_rdata, exp_data);
    check("resp_err", resp_err, exp_err);
    check("ram_cs_count", 64'(cs_pulses - cs0), exp_err ? 64'd0 : 64'd1);
    got = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, exp_data);
      check("hold_err", resp_err, exp_err);
      check("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge clk);
    check("resp_consumed", resp_valid, 0);
    check("ready_after_resp", req_ready, 1);
    check("ram_cs_total", 64'(cs_pulses - cs0), exp_err ? 64'd0 : 64'd1);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] ra;
    logic        rerr;
    logic [63:0] rdat;
    int          rlat;
    int          cs0;

    for (int i = 0; i < MEMB; i++) begin
      ram_arr[i] = 8'h00;
      shadow[i]  = 8'h00;
    end
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_width = 2'd0;
    req_signed = 1'b0; req_wdata = '1; resp_ready = 1'b0; ram_rdata = 64'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_no_cs_pulse", 64'(cs_pulses), 0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1);
    @(negedge clk);

    // Basic 64-bit store/load.
    do_req(1, BASE + 64'h10, 2'd0, 0, 64'h1122334455667788, 0, 0, got);
    do_req(0, BASE + 64'h10, 2'd0, 0, 64'd0, 0, 0, got);
    check("plan_load64", got, 64'h1122334455667788);

    // Byte store and signed/unsigned byte loads, neighbours intact.
    do_req(1, BASE + 64'h13, 2'd3, 0, 64'h00000000000000F0, 0, 0, got);
    do_req(0, BASE + 64'h13, 2'd3, 1, 64'd0, 0, 0, got);
    check("plan_byte_signed", got, 64'hFFFFFFFFFFFFFFF0);
    do_req(0, BASE + 64'h13, 2'd3, 0, 64'd0, 0, 0, got);
    check("plan_byte_unsigned", got, 64'h00000000000000F0);
    do_req(0, BASE + 64'h12, 2'd3, 0, 64'd0, 0, 0, got);
    check("plan_neighbour_lo", got, 64'h66);
    do_req(0, BASE + 64'h14, 2'd3, 0, 64'd0, 0, 0, got);
    check("plan_neighbour_hi", got, 64'h44);
    do_req(0, BASE + 64'h10, 2'd0, 0, 64'd0, 0, 0, got);
    check("plan_word_merge", got, 64'h11223344F0667788);

    // Misaligned 32-bit store across a word boundary.
    do_req(1, BASE + 64'h1E, 2'd1, 0, 64'hDEADBEEF80000001, 0, 0, got);
    do_req(0, BASE + 64'h1E, 2'd1, 1, 64'd0, 0, 0, got);
    check("plan_misaligned", got, 64'hFFFFFFFF80000001);
    do_req(0, BASE + 64'h18, 2'd0, 0, 64'd0, 0, 0, got);
    check("plan_misaligned_lo_word", got, 64'h0001000000000000);
    do_req(0, BASE + 64'h20, 2'd2, 0, 64'd0, 0, 0, got);
    check("plan_misaligned_hi_half", got, 64'h8000);

    // Range boundaries, including address wrap.
    do_req(0, BASE - 64'd1, 2'd3, 0, 64'd0, 0, 0, got);
    do_req(0, BASE + 64'(MEMB) - 64'd8, 2'd0, 0, 64'd0, 0, 0, got);
    do_req(0, BASE + 64'(MEMB) - 64'd9, 2'd3, 0, 64'd0, 0, 0, got);
    do_req(0, BASE + 64'(MEMB) - 64'd16, 2'd0, 0, 64'd0, 0, 0, got);
    do_req(1, BASE + 64'(MEMB) - 64'd8, 2'd3, 0, 64'hAB, 0, 0, got);
    do_req(0, 64'hFFFFFFFFFFFFFFFF, 2'd0, 1, 64'd0, 0, 0, got);

    // Back-pressure with req_valid held high.
    do_req(0, BASE + 64'h10, 2'd0, 0, 64'd0, 5, 1, got);
    do_req(1, BASE + 64'h40, 2'd2, 0, 64'h1234, 5, 1, got);

    // Reset while a read is in flight.
    cs0 = cs_pulses;
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 64'h10; req_width = 2'd0;
    req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rd_wait_rst_valid", resp_valid, 0);
    check("rd_wait_rst_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    check("after_rst_ready", req_ready, 1);
    check("after_rst_cs_count", 64'(cs_pulses - cs0), 1);
    @(negedge clk);
    check("after_rst_no_resp", resp_valid, 0);
    do_req(0, BASE + 64'h10, 2'd0, 0, 64'd0, 0, 0, got);
    check("after_rst_reload", got, 64'h11223344F0667788);

    // Randomized mix near and across the window edges.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 15) == 0) ra = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
      else ra = BASE - 64'd4 + 64'($urandom_range(0, MEMB + 8));
      do_req(1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), got);
    end

    // Final sweep: every in-range word readback matches the shadow.
    for (int a = 0; a + 16 <= MEMB; a += 8) begin
      do_req(0, BASE + 64'(a), 2'd0, 0, 64'd0, 0, 0, got);
    end
    model(0, BASE, 2'd0, 0, 64'd0, rerr, rdat, rlat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
